// File: rtl/exec_stage.sv
// exec_stage: MIPS execute stage. Performs the ALU operation selected by
// alucontrol and registers the result plus pass-through control into the
// EX/MEM pipeline register, with downstream stall and flush.
// Optional feature macro: EXEC_MULT_EN enables the iterative shift-add
// multiplier (code 011) and its IDLE/MUL FSM; otherwise 011 yields 0.
//
//   state | meaning
//   IDLE  | stage accepts single-cycle ops or starts a multiply
//   MUL   | multiply in progress, upstream held off (ready = 0)
module exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [WIDTH-1:0] writedata,
  input  logic [4:0]       writereg,
  input  logic             regwrite,
  input  logic             memwrite,
  input  logic             memtoreg,
  input  logic             stall_in,
  input  logic             flush,
  output logic             ready,
  output logic             valid_m,
  output logic [WIDTH-1:0] aluout_m,
  output logic [WIDTH-1:0] writedata_m,
  output logic [4:0]       writereg_m,
  output logic             regwrite_m,
  output logic             memwrite_m,
  output logic             memtoreg_m,
  output logic             zero_m
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [WIDTH-1:0] alu_result;
  logic             accept;
  logic             single_op;

  // Multiplier-side view of the datapath; tied off when the feature is out.
  logic             mul_done;
  logic [WIDTH-1:0] mul_result;
  logic [WIDTH-1:0] mul_writedata;
  logic [4:0]       mul_writereg;
  logic             mul_regwrite;
  logic             mul_memwrite;
  logic             mul_memtoreg;

  // Single-cycle ALU; undefined codes (and 011 here) give 0.
  always_comb begin
    alu_result = '0;
    case (alucontrol)
      OP_ADD:  alu_result = srca + srcb;
      OP_SUB:  alu_result = srca - srcb;
      OP_AND:  alu_result = srca & srcb;
      OP_OR:   alu_result = srca | srcb;
      OP_SLT:  alu_result = ($signed(srca) < $signed(srcb)) ? WIDTH'(1) : '0;
      default: alu_result = '0;
    endcase
  end

  assign accept = in_valid && ready && !flush;

`ifdef EXEC_MULT_EN
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state;
  state_t           state_next;
  logic             busy;
  logic             mul_start;
  logic             count_full;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;

  assign mul_start  = accept && (alucontrol == OP_MUL);
  assign single_op  = accept && (alucontrol != OP_MUL);
  assign count_full = (count == CW'(WIDTH));

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // FSM next-state logic; flush abandons a running multiply.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (mul_start) state_next = S_MUL;
      S_MUL: begin
        if (flush)                         state_next = S_IDLE;
        else if (count_full && !stall_in)  state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy     = (state == S_MUL);
    mul_done = (state == S_MUL) && count_full && !stall_in && !flush;
  end

  assign ready = !stall_in && !busy;

  // Shift-add datapath: multiplicand walks left and multiplier walks right,
  // which is the same as testing bit[count] and adding mcand << count.
  // Count saturates at WIDTH so a stalled completion just waits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count         <= '0;
      mcand         <= '0;
      mplier        <= '0;
      acc           <= '0;
      mul_writedata <= '0;
      mul_writereg  <= '0;
      mul_regwrite  <= 1'b0;
      mul_memwrite  <= 1'b0;
      mul_memtoreg  <= 1'b0;
    end else if (mul_start) begin
      count         <= '0;
      mcand         <= srca;
      mplier        <= srcb;
      acc           <= '0;
      mul_writedata <= writedata;
      mul_writereg  <= writereg;
      mul_regwrite  <= regwrite;
      mul_memwrite  <= memwrite;
      mul_memtoreg  <= memtoreg;
    end else if (busy && !count_full) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
    end
  end

  assign mul_result = acc;
`else
  assign ready         = !stall_in;
  assign single_op     = accept;
  assign mul_done      = 1'b0;
  assign mul_result    = '0;
  assign mul_writedata = '0;
  assign mul_writereg  = '0;
  assign mul_regwrite  = 1'b0;
  assign mul_memwrite  = 1'b0;
  assign mul_memtoreg  = 1'b0;
`endif

  // EX/MEM register: flush beats stall, stall holds, otherwise load a
  // finished multiply, an accepted op, or a bubble.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_m     <= 1'b0;
      aluout_m    <= '0;
      writedata_m <= '0;
      writereg_m  <= '0;
      regwrite_m  <= 1'b0;
      memwrite_m  <= 1'b0;
      memtoreg_m  <= 1'b0;
      zero_m      <= 1'b0;
    end else if (flush) begin
      valid_m    <= 1'b0;
      regwrite_m <= 1'b0;
      memwrite_m <= 1'b0;
    end else if (stall_in) begin
      valid_m <= valid_m;
    end else if (mul_done) begin
      valid_m     <= 1'b1;
      aluout_m    <= mul_result;
      writedata_m <= mul_writedata;
      writereg_m  <= mul_writereg;
      regwrite_m  <= mul_regwrite;
      memwrite_m  <= mul_memwrite;
      memtoreg_m  <= mul_memtoreg;
      zero_m      <= (mul_result == '0);
    end else if (single_op) begin
      valid_m     <= 1'b1;
      aluout_m    <= alu_result;
      writedata_m <= writedata;
      writereg_m  <= writereg;
      regwrite_m  <= regwrite;
      memwrite_m  <= memwrite;
      memtoreg_m  <= memtoreg;
      zero_m      <= (alu_result == '0);
    end else begin
      valid_m    <= 1'b0;
      regwrite_m <= 1'b0;
      memwrite_m <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Directed testbench for exec_stage. Multiply scenarios run when the bench
// is compiled with EXEC_MULT_EN; otherwise the macro-off behaviour is checked.
module tb_exec_stage;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             resetn;
  logic             in_valid;
  logic [2:0]       alucontrol;
  logic [WIDTH-1:0] srca, srcb, writedata;
  logic [4:0]       writereg;
  logic             regwrite, memwrite, memtoreg;
  logic             stall_in, flush;
  logic             ready, valid_m;
  logic [WIDTH-1:0] aluout_m, writedata_m;
  logic [4:0]       writereg_m;
  logic             regwrite_m, memwrite_m, memtoreg_m, zero_m;

  int checks = 0;
  int errors = 0;

  exec_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .alucontrol(alucontrol),
    .srca(srca), .srcb(srcb), .writedata(writedata), .writereg(writereg),
    .regwrite(regwrite), .memwrite(memwrite), .memtoreg(memtoreg),
    .stall_in(stall_in), .flush(flush), .ready(ready), .valid_m(valid_m),
    .aluout_m(aluout_m), .writedata_m(writedata_m), .writereg_m(writereg_m),
    .regwrite_m(regwrite_m), .memwrite_m(memwrite_m), .memtoreg_m(memtoreg_m),
    .zero_m(zero_m)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [2:0] code, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] wd,
                          input logic [4:0] wr, input logic rw, input logic mw,
                          input logic mtr);
    in_valid   = 1'b1;
    alucontrol = code;
    srca       = a;
    srcb       = b;
    writedata  = wd;
    writereg   = wr;
    regwrite   = rw;
    memwrite   = mw;
    memtoreg   = mtr;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    stall_in = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    stall_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_op(3'($urandom_range(7)), $urandom, $urandom, $urandom,
               5'($urandom_range(31)), 1'b1, 1'b1, 1'b1);
      flush = 1'($urandom_range(1));
      step();
    end
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_m); end
    checks++; if (aluout_m !== '0) begin errors++; $display("FAIL reset_aluout: got %h want 0", aluout_m); end
    checks++; if (writedata_m !== '0) begin errors++; $display("FAIL reset_writedata: got %h want 0", writedata_m); end
    checks++; if (writereg_m !== 5'd0) begin errors++; $display("FAIL reset_writereg: got %h want 0", writereg_m); end
    checks++; if ({regwrite_m, memwrite_m, memtoreg_m, zero_m} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {regwrite_m, memwrite_m, memtoreg_m, zero_m}); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    idle_inputs();
    resetn = 1'b1;
    step();
    drive_op(3'b010, 32'd5, 32'd7, 32'hAB, 5'd3, 1'b1, 1'b0, 1'b0);
    step();
    checks++; if (aluout_m !== 32'd12) begin errors++; $display("FAIL first_add: got %0d want 12", aluout_m); end
    checks++; if (zero_m !== 1'b0) begin errors++; $display("FAIL first_add_zero: got %b want 0", zero_m); end
    checks++; if (valid_m !== 1'b1) begin errors++; $display("FAIL first_add_valid: got %b want 1", valid_m); end
    checks++; if (writereg_m !== 5'd3 || regwrite_m !== 1'b1 || writedata_m !== 32'hAB) begin
      errors++; $display("FAIL first_add_fields: got wr=%0d rw=%b wd=%h want wr=3 rw=1 wd=ab", writereg_m, regwrite_m, writedata_m); end
  endtask

  task automatic test_ops();
    logic [2:0]       codes [6] = '{3'b110, 3'b000, 3'b001, 3'b111, 3'b111, 3'b100};
    logic [WIDTH-1:0] as    [6] = '{32'd7, 32'hF0F0, 32'hF0F0, 32'hFFFFFFFF, 32'd1, 32'd9};
    logic [WIDTH-1:0] bs    [6] = '{32'd7, 32'hFF00, 32'hFF00, 32'd1, 32'hFFFFFFFF, 32'd9};
    logic [WIDTH-1:0] exps  [6] = '{32'd0, 32'hF000, 32'hFFF0, 32'd1, 32'd0, 32'd0};
    for (int i = 0; i < 6; i++) begin
      drive_op(codes[i], as[i], bs[i], 32'h1000 + 32'(i), 5'(i + 8), 1'b1, 1'b1, 1'b1);
      step();
      checks++; if (aluout_m !== exps[i]) begin
        errors++; $display("FAIL op_%0d_result: code %b got %h want %h", i, codes[i], aluout_m, exps[i]); end
      checks++; if (zero_m !== (exps[i] == '0) || valid_m !== 1'b1) begin
        errors++; $display("FAIL op_%0d_zero_valid: got z=%b v=%b want z=%b v=1", i, zero_m, valid_m, exps[i] == '0); end
      checks++; if ({regwrite_m, memwrite_m, memtoreg_m} !== 3'b111 || writereg_m !== 5'(i + 8)) begin
        errors++; $display("FAIL op_%0d_passthru: got ctrl=%b wr=%0d want 111 wr=%0d", i, {regwrite_m, memwrite_m, memtoreg_m}, writereg_m, i + 8); end
    end
  endtask

  task automatic test_bubble();
    idle_inputs();
    step();
    checks++; if ({valid_m, regwrite_m, memwrite_m} !== 3'b000) begin
      errors++; $display("FAIL bubble: got v/rw/mw=%b want 000", {valid_m, regwrite_m, memwrite_m}); end
  endtask

  task automatic test_stall_flush();
    drive_op(3'b010, 32'd1, 32'd2, 32'h55, 5'd4, 1'b1, 1'b0, 1'b1);
    step();
    drive_op(3'b110, 32'd100, 32'd1, 32'h66, 5'd9, 1'b0, 1'b1, 1'b0);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL stall_ready_%0d: got %b want 0", i, ready); end
      step();
      checks++; if (aluout_m !== 32'd3 || valid_m !== 1'b1 || writereg_m !== 5'd4 || memtoreg_m !== 1'b1) begin
        errors++; $display("FAIL stall_hold_%0d: got out=%h v=%b wr=%0d want 3 1 4", i, aluout_m, valid_m, writereg_m); end
    end
    flush = 1'b1;
    drive_op(3'b010, 32'd1, 32'd1, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0);
    step();
    checks++; if ({valid_m, regwrite_m, memwrite_m} !== 3'b000) begin
      errors++; $display("FAIL flush_clear: got v/rw/mw=%b want 000", {valid_m, regwrite_m, memwrite_m}); end
    idle_inputs();
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL post_flush_ready: got %b want 1", ready); end
    step();
  endtask

`ifdef EXEC_MULT_EN
  task automatic run_mul(input string name, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp);
    int edges;
    int low;
    drive_op(3'b011, a, b, 32'h77, 5'd12, 1'b1, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    edges = 0;
    low = 0;
    while (valid_m !== 1'b1 && edges < 100) begin
      if (ready === 1'b0) low++;
      step();
      edges++;
    end
    checks++; if (edges != 33) begin errors++; $display("FAIL %s_latency: got %0d edges want 33", name, edges); end
    checks++; if (low != 33) begin errors++; $display("FAIL %s_ready_low: got %0d cycles want 33", name, low); end
    checks++; if (aluout_m !== exp || writereg_m !== 5'd12) begin
      errors++; $display("FAIL %s_result: got %h wr=%0d want %h wr=12", name, aluout_m, writereg_m, exp); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL %s_ready_after: got %b want 1", name, ready); end
    step();
  endtask

  task automatic test_mul();
    run_mul("mul_123x456", 32'd123, 32'd456, 32'd56088);
    run_mul("mul_ffx2", 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);
  endtask

  task automatic test_mul_abort();
    drive_op(3'b011, 32'd9, 32'd9, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", ready); end
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid_m !== 1'b0) break;
    end
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL abort_no_result: got valid %b want 0", valid_m); end
    drive_op(3'b011, 32'd9, 32'd9, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    resetn = 1'b0;
    #1;
    checks++; if (ready !== 1'b1 || valid_m !== 1'b0 || aluout_m !== '0 || writereg_m !== 5'd0) begin
      errors++; $display("FAIL reset_mid_mul: got rdy=%b v=%b out=%h want 1 0 0", ready, valid_m, aluout_m); end
    step();
    resetn = 1'b1;
    for (int i = 0; i < 40; i++) step();
    checks++; if (valid_m !== 1'b0 || ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_mul_after: got v=%b rdy=%b want 0 1", valid_m, ready); end
  endtask
`else
  task automatic test_mul_off();
    drive_op(3'b011, 32'd3, 32'd4, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL muloff_ready_before: got %b want 1", ready); end
    step();
    checks++; if (aluout_m !== '0 || valid_m !== 1'b1 || zero_m !== 1'b1 || regwrite_m !== 1'b1) begin
      errors++; $display("FAIL muloff_result: got out=%h v=%b z=%b want 0 1 1", aluout_m, valid_m, zero_m); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL muloff_ready_after: got %b want 1", ready); end
    drive_op(3'b010, 32'd20, 32'd22, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0);
    step();
    checks++; if (aluout_m !== 32'd42 || writereg_m !== 5'd7) begin
      errors++; $display("FAIL muloff_next_op: got %0d wr=%0d want 42 wr=7", aluout_m, writereg_m); end
    idle_inputs();
    step();
  endtask
`endif

  initial begin
    resetn = 1'b0;
    idle_inputs();
    alucontrol = 3'b000;
    srca = '0; srcb = '0; writedata = '0; writereg = '0;
    regwrite = 1'b0; memwrite = 1'b0; memtoreg = 1'b0;
    test_reset();
    test_ops();
    test_bubble();
    test_stall_flush();
`ifdef EXEC_MULT_EN
    test_mul();
    test_mul_abort();
`else
    test_mul_off();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
